// File: rtl/ex_mem_result_sched.sv
// rtl/ex_mem_result_sched.sv - EX/MEM result register shared by the ALU and a 32-cycle shift-add multiplier
module ex_mem_result_sched #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        ex_is_mul,
    input  logic [31:0] data_from_ALU,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall_ex,
    output logic        busy,
    output logic [31:0] data_for_Mem_stage,
    output logic        mem_valid
);

    localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
    logic [31:0] addend;

    assign addend   = mplier[0] ? mcand : 32'd0;
    assign busy     = (state == BUSY);
    // Release the stall in the last BUSY cycle so the next instruction enters EX as the product retires.
    assign stall_ex = !flush && (((state == IDLE) && ex_valid && ex_is_mul) ||
                                 ((state == BUSY) && (cnt != CNT_LAST)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            acc                <= 32'd0;
            mcand              <= 32'd0;
            mplier             <= 32'd0;
            cnt                <= 5'd0;
            data_for_Mem_stage <= 32'd0;
            mem_valid          <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            mem_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_valid && ex_is_mul) begin
                        mcand     <= op_a;
                        mplier    <= op_b;
                        acc       <= 32'd0;
                        cnt       <= 5'd0;
                        state     <= BUSY;
                        mem_valid <= 1'b0;
                    end else if (ex_valid) begin
                        data_for_Mem_stage <= data_from_ALU;
                        mem_valid          <= 1'b1;
                    end else begin
                        mem_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc       <= acc + addend;
                    mcand     <= mcand << 1;
                    mplier    <= mplier >> 1;
                    cnt       <= cnt + 5'd1;
                    mem_valid <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        data_for_Mem_stage <= acc + addend;
                        mem_valid          <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_result_sched.sv
// tb/tb_ex_mem_result_sched.sv - self-checking bench for ex_mem_result_sched
module tb_ex_mem_result_sched;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_is_mul = 1'b0;
    logic [31:0] data_from_ALU = 32'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall_ex;
    logic        busy;
    logic [31:0] data_for_Mem_stage;
    logic        mem_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;
    int busy_cnt;

    ex_mem_result_sched #(.MUL_CYCLES(32)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_is_mul(ex_is_mul),
        .data_from_ALU(data_from_ALU), .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall_ex(stall_ex), .busy(busy), .data_for_Mem_stage(data_for_Mem_stage),
        .mem_valid(mem_valid)
    );

    always #5 clock = ~clock;

    // Reference: a multiply is a countdown of remaining edges plus its full product.
    int          m_left = 0;
    logic [31:0] m_prod = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic        m_valid = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0; m_data = 32'd0; m_valid = 1'b0;
        end else if (flush) begin
            m_left = 0; m_valid = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_valid = (m_left == 0);
            if (m_left == 0) m_data = m_prod;
        end else if (ex_valid && ex_is_mul) begin
            m_prod = op_a * op_b;
            m_left = 32;
            m_valid = 1'b0;
        end else if (ex_valid) begin
            m_data = data_from_ALU;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            chk("model_stall", 32'(stall_ex),
                32'(!flush && ((m_left == 0 && ex_valid && ex_is_mul) || m_left > 1)));
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_valid", 32'(mem_valid), 32'(m_valid));
            chk("model_data", data_for_Mem_stage, m_data);
        end
    end

    // Present inputs for one cycle, sample stall/busy mid-cycle, return 1ns after the edge.
    task automatic step(input logic v, input logic m, input logic [31:0] alu,
                        input logic [31:0] a, input logic [31:0] b, input logic f);
        ex_valid = v; ex_is_mul = m; data_from_ALU = alu; op_a = a; op_b = b; flush = f;
        #1;
        if (stall_ex) stall_cnt++;
        if (busy) busy_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input string name);
        int n;
        stall_cnt = 0; busy_cnt = 0;
        step(1'b1, 1'b1, 32'd0, a, b, 1'b0);
        n = 1;
        while (!mem_valid && n < 40) begin
            idle();
            n++;
        end
        chk({name, "_edges"}, 32'(n), 32'd33);
        chk({name, "_data"}, data_for_Mem_stage, exp);
        chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'd32);
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
        idle();
        chk({name, "_single_pulse"}, 32'(mem_valid), 32'd0);
    endtask

    logic [31:0] corner [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd1, 32'h0001_0000, 32'd2};

    function automatic logic [31:0] pick();
        if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] saved;
        int n;
        #2;
        chk("reset_data", data_for_Mem_stage, 32'd0);
        chk("reset_valid", 32'(mem_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall_ex), 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clock); #1;

        stall_cnt = 0;
        step(1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 1'b0);
        chk("alu1_data", data_for_Mem_stage, 32'h1234_5678);
        chk("alu1_valid", 32'(mem_valid), 32'd1);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
        chk("alu2_data", data_for_Mem_stage, 32'hDEAD_BEEF);
        chk("alu2_valid", 32'(mem_valid), 32'd1);
        chk("alu_no_stall", 32'(stall_cnt), 32'd0);
        idle();

        do_mul(32'd7, 32'd6, 32'h0000_002A, "mul_7x6");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ffx");
        do_mul(32'h8000_0000, 32'd2, 32'h0000_0000, "mul_8x2");
        do_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_16x16");

        // MUL held in EX while stalled, then ALU 0x55 behind it.
        step(1'b1, 1'b1, 32'd0, 32'd9, 32'd9, 1'b0);
        n = 0;
        while (busy && n < 40) begin
            step(1'b1, 1'b1, 32'd0, 32'd9, 32'd9, 1'b0);
            n++;
        end
        chk("queued_mul_data", data_for_Mem_stage, 32'd81);
        chk("queued_mul_valid", 32'(mem_valid), 32'd1);
        step(1'b1, 1'b0, 32'h55, 32'd0, 32'd0, 1'b0);
        chk("queued_alu_data", data_for_Mem_stage, 32'h55);
        chk("queued_alu_valid", 32'(mem_valid), 32'd1);
        idle();

        // Flush at BUSY cnt = 10.
        step(1'b1, 1'b1, 32'd0, 32'd123, 32'd456, 1'b0);
        for (int i = 0; i < 10; i++) idle();
        saved = data_for_Mem_stage;
        ex_valid = 1'b0; ex_is_mul = 1'b0; flush = 1'b1;
        #1;
        chk("flush_stall_low", 32'(stall_ex), 32'd0);
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(mem_valid), 32'd0);
        chk("flush_data_held", data_for_Mem_stage, saved);
        step(1'b1, 1'b0, 32'hCAFE_0001, 32'd0, 32'd0, 1'b0);
        chk("post_flush_alu", data_for_Mem_stage, 32'hCAFE_0001);
        for (int i = 0; i < 40; i++) begin
            idle();
            if (mem_valid) chk("flush_no_result", 32'(mem_valid), 32'd0);
        end

        // Asynchronous reset at cnt = 20.
        step(1'b1, 1'b1, 32'd0, 32'd11, 32'd13, 1'b0);
        for (int i = 0; i < 20; i++) idle();
        #1 reset_n = 1'b0;
        #1;
        chk("areset_data", data_for_Mem_stage, 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_valid", 32'(mem_valid), 32'd0);
        chk("areset_stall", 32'(stall_ex), 32'd0);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        do_mul(32'd3, 32'd5, 32'h0000_000F, "mul_3x5");

        // Random traffic, checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(9) != 0), ($urandom_range(7) == 0), $urandom, pick(), pick(),
                 ($urandom_range(49) == 0));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
